// File: rtl/baud_rate_generator_frac.sv
`default_nettype none
// ============================================================================
//  Module      : baud_rate_generator_frac
//  Description : Fractional baud rate generator with runtime 16x/8x
//                oversampling. A phase accumulator stretches the oversample
//                period by one clock whenever the fractional part overflows,
//                so the mean ov period is D + 1 + F/2^FRAC_WIDTH clocks.
//                Produces the oversample tick, the bit-rate tick and a
//                mid-bit strobe. Divisor/mode writes go to a shadow set and
//                become active only on a bit boundary or while disabled.
//
//  Ports       : clk_i          system clock
//                rst_n_i        synchronous active-low reset
//                enable_i       1 = run, 0 = counters held at zero
//                load_i         strobe: capture divisor_i/frac_i/ovs8_i
//                divisor_i      integer divisor D
//                frac_i         fractional divisor F
//                ovs8_i         0 = 16x oversampling, 1 = 8x
//                ov_tick_o      oversample-rate pulse
//                baud_tick_o    bit-rate pulse (last ov tick of a bit)
//                mid_bit_o      pulse on the mid-bit ov tick
//                ovs_cnt_o      oversample index within the current bit
//                cfg_pending_o  shadow config captured but not yet active
//
//  Revision    : 1.0  initial release
// ============================================================================
module baud_rate_generator_frac #(
    parameter int unsigned DVSR_WIDTH = 16,
    parameter int unsigned FRAC_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  enable_i,
    input  logic                  load_i,
    input  logic [DVSR_WIDTH-1:0] divisor_i,
    input  logic [FRAC_WIDTH-1:0] frac_i,
    input  logic                  ovs8_i,
    output logic                  ov_tick_o,
    output logic                  baud_tick_o,
    output logic                  mid_bit_o,
    output logic [3:0]            ovs_cnt_o,
    output logic                  cfg_pending_o
);

    // The period counter is one bit wider than the divisor: with D all-ones
    // and a fractional carry the terminal count is 2^DVSR_WIDTH.
    localparam int unsigned           c_CNT_W   = DVSR_WIDTH + 1;
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE = {{DVSR_WIDTH{1'b0}}, 1'b1};
    localparam logic [3:0]            c_LAST16  = 4'd15;
    localparam logic [3:0]            c_LAST8   = 4'd7;
    localparam logic [3:0]            c_MID16   = 4'd7;
    localparam logic [3:0]            c_MID8    = 4'd3;

    logic [c_CNT_W-1:0]    r_cnt;
    logic [FRAC_WIDTH-1:0] r_acc;
    logic [3:0]            r_ovs_cnt;
    logic [DVSR_WIDTH-1:0] r_act_d;
    logic [FRAC_WIDTH-1:0] r_act_f;
    logic                  r_act_ovs8;
    logic [DVSR_WIDTH-1:0] r_shd_d;
    logic [FRAC_WIDTH-1:0] r_shd_f;
    logic                  r_shd_ovs8;
    logic                  r_pending;

    logic [FRAC_WIDTH:0]   w_frac_sum;
    logic                  w_ext;
    logic [c_CNT_W-1:0]    w_term;
    logic [3:0]            w_ovs_last;
    logic [3:0]            w_ovs_mid;
    logic                  w_ov_tick;
    logic                  w_baud_tick;
    logic                  w_mid_bit;
    logic                  w_apply;

    // The carry that the accumulator will produce at the end of this period
    // decides whether this period is one clock longer.
    assign w_frac_sum  = {1'b0, r_acc} + {1'b0, r_act_f};
    assign w_ext       = w_frac_sum[FRAC_WIDTH];
    assign w_term      = {1'b0, r_act_d} + {{DVSR_WIDTH{1'b0}}, w_ext};

    assign w_ovs_last  = r_act_ovs8 ? c_LAST8 : c_LAST16;
    assign w_ovs_mid   = r_act_ovs8 ? c_MID8  : c_MID16;

    // Gated by reset and enable so that a zero terminal count (D=0, cnt=0)
    // cannot leak a tick while held idle or in reset.
    assign w_ov_tick   = rst_n_i & enable_i & (r_cnt == w_term);
    assign w_baud_tick = w_ov_tick & (r_ovs_cnt == w_ovs_last);
    assign w_mid_bit   = w_ov_tick & (r_ovs_cnt == w_ovs_mid);

    // Shadow config may only become active where no period is in flight.
    assign w_apply     = ~enable_i | w_baud_tick;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_ovs_cnt  <= '0;
            r_act_d    <= '0;
            r_act_f    <= '0;
            r_act_ovs8 <= 1'b0;
            r_shd_d    <= '0;
            r_shd_f    <= '0;
            r_shd_ovs8 <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            if (!enable_i) begin
                r_cnt     <= '0;
                r_acc     <= '0;
                r_ovs_cnt <= '0;
            end else if (w_ov_tick) begin
                r_cnt     <= '0;
                r_acc     <= w_frac_sum[FRAC_WIDTH-1:0];
                // ">=" also recovers an out-of-range index without a baud tick
                r_ovs_cnt <= (r_ovs_cnt >= w_ovs_last) ? 4'd0 : r_ovs_cnt + 4'd1;
            end else begin
                r_cnt     <= r_cnt + c_CNT_ONE;
            end

            if (w_apply) begin
                r_act_d    <= r_shd_d;
                r_act_f    <= r_shd_f;
                r_act_ovs8 <= r_shd_ovs8;
            end

            // A load coinciding with an apply lands in the shadow only and
            // stays pending until the following boundary.
            if (load_i) begin
                r_shd_d    <= divisor_i;
                r_shd_f    <= frac_i;
                r_shd_ovs8 <= ovs8_i;
                r_pending  <= 1'b1;
            end else if (w_apply) begin
                r_pending  <= 1'b0;
            end
        end
    end

    assign ov_tick_o     = w_ov_tick;
    assign baud_tick_o   = w_baud_tick;
    assign mid_bit_o     = w_mid_bit;
    assign ovs_cnt_o     = r_ovs_cnt;
    assign cfg_pending_o = r_pending;

endmodule
`default_nettype wire
